clk_div_ratio_ctrl: RTL
=======================

# clk_div_ratio_ctrl

Sequencing and arbitration controller that sits in front of the clock divider and owns its `i_div_ratio` and `i_clk_en` inputs. Up to NUM_REQ requesters ask for a new division ratio. The block grants one request at a time in round-robin order and range-checks the ratio. It then runs a safe change sequence: gate the divider off, drain, load the ratio, settle, and re-enable. This keeps the divider from ever seeing a ratio change while it is running.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_RATIO, 1023, largest accepted ratio; matches the divider counter width
- RESET_RATIO, 2, value of o_div_ratio out of reset
- DRAIN_CYCLES, 4, number of ref cycles with the divider gated off before the ratio is loaded (1..255)
- SETTLE_CYCLES, 2, number of ref cycles after loading before re-enable (1..255)

- i_ref_clk  in  1  reference clock; all logic is rising-edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  master enable for the divider output
- i_req  in  NUM_REQ  per-requester level request, held until its grant
- i_req_ratio  in  NUM_REQ*32  requested ratios; requester k uses bits [32k+31:32k]
- o_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- o_err  out  1  one-cycle pulse, coincident with o_gnt, when the granted ratio is rejected
- o_busy  out  1  change sequence in progress
- o_div_ratio  out  32  ratio driven to the divider
- o_clk_en  out  1  enable driven to the divider

## Operation
- Reset values:
  - o_div_ratio = RESET_RATIO.
  - o_clk_en, o_gnt, o_err and o_busy = 0.
  - Round-robin pointer = 0.
  - State = IDLE.
  - Reset is asynchronous at any point, including mid-sequence; the captured ratio is discarded.
- All outputs are registered.
- States are IDLE, DRAIN, LOAD and SETTLE.
- Arbitration in IDLE:
  - Search i_req starting at the pointer index, wrapping upward.
  - The first set bit wins. Its ratio r is captured at the same edge, and o_gnt[winner] pulses the next cycle.
  - The pointer becomes winner+1 mod NUM_REQ on every grant, including rejected and no-op grants.
- Grant outcomes:
  - **Reject.** r < 2 or r > MAX_RATIO: o_err pulses with o_gnt. State stays IDLE; o_div_ratio and o_clk_en are unchanged.
  - **No-op.** r == o_div_ratio and o_clk_en == 1: grant only. State stays IDLE.
  - **Change.** Any other case: go to DRAIN. o_clk_en goes to 0 and o_busy to 1, both on the grant edge.
- DRAIN:
  - An 8-bit counter runs for DRAIN_CYCLES cycles, then the block enters LOAD.
- LOAD:
  - Lasts one cycle.
  - On exit, o_div_ratio is set to r and the counter is cleared.
- SETTLE:
  - Lasts SETTLE_CYCLES cycles.
  - On exit: o_clk_en = i_enable sampled at that edge, o_busy = 0, state = IDLE.
- i_enable handling in IDLE with no request:
  - o_clk_en follows i_enable with one-cycle latency.
  - o_div_ratio is always valid, so no drain is required.
- Simultaneous request and i_enable change in IDLE: the request is serviced first. i_enable is applied at the end of the sequence, or on the next idle edge for reject/no-op.
- Requests while busy are not sampled. Held requests are arbitrated on the first IDLE edge after o_busy falls.
- A requester that drops i_req before being granted receives no grant.
- i_req_ratio is only sampled at the grant edge. Later changes have no effect until a new request.
- i_enable low during DRAIN, LOAD or SETTLE does not abort the sequence; it only affects the final o_clk_en value.

## Timing
- Let edge 0 be the IDLE edge that samples i_req.
- Edge 0:
  - o_gnt (and o_err, if rejected) is high for cycle 0→1.
  - On a change, o_clk_en falls and o_busy rises.
- Edge D = DRAIN_CYCLES: state becomes LOAD.
- Edge D+1: o_div_ratio takes the new value.
- Edge D+1+S (S = SETTLE_CYCLES):
  - o_clk_en rises (if i_enable) and o_busy falls.
  - With defaults this is edge 7.
- Next grant: earliest at edge D+2+S.
- Minimum spacing between back-to-back grants: 1 cycle for reject/no-op, D+S+2 cycles for a change.
- o_div_ratio never changes while o_clk_en == 1.
- o_clk_en is 0 for at least D+S+1 cycles around every ratio change.

## Test plan
- **Reset then enable.** Release reset with i_enable=1 → o_clk_en=1 one cycle later, o_div_ratio=2.
- **Single change.** req[1] with ratio 6 → o_gnt=0010 after edge 0, o_clk_en low edges 0..6, o_div_ratio=6 at edge 5, o_clk_en high and o_busy low at edge 7.
- **Round robin.** req=1111 held, all with valid distinct ratios → grants in order 0,1,2,3,0; none overlaps a busy window.
- **Rejects and no-op.** Ratio 1 → o_gnt+o_err, no change. Ratio 1024 → o_err. Ratio equal to the current ratio with o_clk_en=1 → grant only, o_clk_en stays high.
- **Enable interplay.** i_enable drops during DRAIN → the sequence completes with o_div_ratio updated and o_clk_en stays 0. Raising i_enable in IDLE → o_clk_en=1 next cycle.
- **Reset mid-sequence.** Assert i_rst_n=0 during SETTLE → all outputs at reset values immediately, o_div_ratio=2, pointer=0.

Source files
------------

// File: rtl/clk_div_ratio_ctrl_if.sv
// Ratio request bus: level requests with per-lane ratios,
// answered by a one-hot grant pulse and a reject flag.
interface clk_div_ratio_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ*32-1:0] i_req_ratio;
    logic [NUM_REQ-1:0]    o_gnt;
    logic                  o_err;

    modport master (
        output i_req,
        output i_req_ratio,
        input  o_gnt,
        input  o_err
    );

    modport slave (
        input  i_req,
        input  i_req_ratio,
        output o_gnt,
        output o_err
    );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Round-robin ratio arbiter that gates the divider off,
// drains, loads the new ratio and settles before re-enabling.
module clk_div_ratio_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_RATIO     = 1023,
    parameter int RESET_RATIO   = 2,
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    clk_div_ratio_ctrl_if.slave  req_if,
    output logic                 o_busy,
    output logic [31:0]          o_div_ratio,
    output logic                 o_clk_en
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_SETTLE
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [7:0]           cnt_q;
    logic [31:0]          pend_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 err_q;
    logic                 busy_q;
    logic [31:0]          ratio_q;
    logic                 clk_en_q;

    logic [31:0]          ratio_a [NUM_REQ];
    logic [PW-1:0]        idx;
    logic [PW-1:0]        win;
    logic                 found;
    logic [PW-1:0]        ptr_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [31:0]          win_ratio;
    logic                 bad;
    logic                 noop;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            ratio_a[k] = req_if.i_req_ratio[k*32 +: 32];
        end
    end

    // First set request at or above the pointer, wrapping upward
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_if.i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        ptr_d      = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        win_ratio  = ratio_a[win];
        bad        = (win_ratio < 32'd2) ||
                     (win_ratio > 32'(MAX_RATIO));
        noop       = (win_ratio == ratio_q) && clk_en_q;
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ratio_q  <= 32'(RESET_RATIO);
            clk_en_q <= 1'b0;
        end else begin
            gnt_q <= '0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        gnt_q <= gnt_d;
                        ptr_q <= ptr_d;
                        if (bad) begin
                            err_q <= 1'b1;
                        end else if (!noop) begin
                            pend_q   <= win_ratio;
                            clk_en_q <= 1'b0;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= S_DRAIN;
                        end
                    end else begin
                        clk_en_q <= i_enable;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == 8'(DRAIN_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_LOAD: begin
                    ratio_q <= pend_q;
                    cnt_q   <= '0;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        clk_en_q <= i_enable;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_if.o_gnt = gnt_q;
    assign req_if.o_err = err_q;
    assign o_busy       = busy_q;
    assign o_div_ratio  = ratio_q;
    assign o_clk_en     = clk_en_q;
endmodule
